// File: rtl/robber_pkg.sv
// Shared types and character helpers for the Rövarspråket stream codec.
// Classification treats only ASCII A-Z/a-z as letters.
package robber_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENC_PASS = 3'd1,
    ST_ENC_FILL = 3'd2,
    ST_ENC_ECHO = 3'd3,
    ST_DEC_PASS = 3'd4,
    ST_DEC_FILL = 3'd5,
    ST_DEC_ECHO = 3'd6
  } state_t;

  localparam int NUM_VOWELS = 6;
  // Lower-case vowels; callers fold case before comparing.
  localparam logic [NUM_VOWELS*8-1:0] VOWEL_LIST = "aeiouy";

  localparam logic [7:0] CASE_MASK = 8'hDF;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h7A);
  endfunction

  function automatic logic is_letter(input logic [7:0] c);
    return is_upper(c) || is_lower(c);
  endfunction

  function automatic logic [7:0] filler_for(input logic [7:0] c,
                                            input logic [7:0] filler,
                                            input logic       case_filler);
    return (case_filler && is_upper(c)) ? (filler & CASE_MASK) : filler;
  endfunction

endpackage

// File: rtl/robber_char_class.sv
// Combinational character classifier: letter / vowel / consonant / upper-case.
// Vowel test folds to lower case, so it is only meaningful for letters.
module robber_char_class
  import robber_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_letter,
  output logic       is_vowel,
  output logic       is_consonant,
  output logic       is_upper
);

  logic [7:0]            ch_lower;
  logic [NUM_VOWELS-1:0] vowel_hit;

  assign ch_lower = ch | 8'h20;

  for (genvar gi = 0; gi < NUM_VOWELS; gi++) begin : g_vowel
    assign vowel_hit[gi] = (ch_lower == VOWEL_LIST[gi*8 +: 8]);
  end

  assign is_letter    = robber_pkg::is_letter(ch);
  assign is_upper     = robber_pkg::is_upper(ch);
  assign is_vowel     = is_letter && (|vowel_hit);
  assign is_consonant = is_letter && !(|vowel_hit);

endmodule

// File: rtl/robber_stream_codec.sv
// Streaming Rövarspråket encoder/decoder with valid/ready on both sides,
// decode error detection with resynchronisation and a saturating error counter.
module robber_stream_codec
  import robber_pkg::*;
#(
  parameter logic [7:0] FILLER      = 8'h6F,
  parameter bit         CASE_FILLER = 1'b1,
  parameter int         ERR_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 encdec,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 err,
  output logic [ERR_WIDTH-1:0] err_count
);

  state_t               state_q, state_d;
  logic [7:0]           hold_q, hold_d;
  logic [7:0]           m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 err_q, err_d;
  logic [ERR_WIDTH-1:0] err_count_q, err_count_d;

  logic       cls_letter, cls_vowel, cls_consonant, cls_upper;
  logic       out_free;
  logic       accept;
  logic [7:0] filler_hold;
  logic       pass_char;
  logic       flag_err;
  logic       unused_class;

  robber_char_class u_class (
    .ch          (s_data),
    .is_letter   (cls_letter),
    .is_vowel    (cls_vowel),
    .is_consonant(cls_consonant),
    .is_upper    (cls_upper)
  );

  // Only the consonant flag steers the FSM; the rest is kept for probing.
  assign unused_class = cls_letter ^ cls_vowel ^ cls_upper;

  assign out_free    = !m_valid_q || m_ready;
  assign filler_hold = filler_for(hold_q, FILLER, CASE_FILLER);

  always_comb begin
    s_ready = 1'b0;
    if (!init) begin
      case (state_q)
        ST_ENC_PASS,
        ST_DEC_PASS,
        ST_DEC_FILL,
        ST_DEC_ECHO: s_ready = out_free;
        default:     s_ready = 1'b0;
      endcase
    end
  end

  assign accept = s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q && !m_ready;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    pass_char   = 1'b0;
    flag_err    = 1'b0;

    if (init) begin
      state_d     = encdec ? ST_ENC_PASS : ST_DEC_PASS;
      m_valid_d   = 1'b0;
      err_count_d = '0;
    end else begin
      case (state_q)
        ST_ENC_PASS: begin
          if (accept) begin
            m_data_d  = s_data;
            m_valid_d = 1'b1;
            if (cls_consonant) begin
              hold_d  = s_data;
              state_d = ST_ENC_FILL;
            end
          end
        end
        ST_ENC_FILL: begin
          if (out_free) begin
            m_data_d  = filler_hold;
            m_valid_d = 1'b1;
            state_d   = ST_ENC_ECHO;
          end
        end
        ST_ENC_ECHO: begin
          if (out_free) begin
            m_data_d  = hold_q;
            m_valid_d = 1'b1;
            state_d   = ST_ENC_PASS;
          end
        end
        ST_DEC_PASS: begin
          pass_char = accept;
        end
        ST_DEC_FILL: begin
          if (accept) begin
            if (s_data == filler_hold) begin
              state_d = ST_DEC_ECHO;
            end else begin
              flag_err  = 1'b1;
              pass_char = 1'b1;
            end
          end
        end
        ST_DEC_ECHO: begin
          if (accept) begin
            if (s_data == hold_q) begin
              state_d = ST_DEC_PASS;
            end else begin
              flag_err  = 1'b1;
              pass_char = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // A mismatching character restarts decoding as if seen in DEC_PASS.
      if (pass_char) begin
        m_data_d  = s_data;
        m_valid_d = 1'b1;
        if (cls_consonant) begin
          hold_d  = s_data;
          state_d = ST_DEC_FILL;
        end else begin
          state_d = ST_DEC_PASS;
        end
      end

      if (flag_err) begin
        err_d = 1'b1;
        if (!(&err_count_q)) begin
          err_count_d = err_count_q + {{(ERR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= 8'h00;
      m_data_q    <= 8'h00;
      m_valid_q   <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign busy      = (state_q == ST_ENC_FILL) || (state_q == ST_ENC_ECHO) ||
                     (state_q == ST_DEC_FILL) || (state_q == ST_DEC_ECHO) ||
                     m_valid_q;

endmodule

// File: tb/tb_robber_stream_codec.sv
// Directed, table-driven bench for robber_stream_codec plus hand-written
// sequences for stalls, init/reset mid-operation and counter saturation.
module tb_robber_stream_codec;
  import robber_pkg::*;

  logic        clk = 1'b0;
  logic        reset, init, encdec, s_valid, m_ready;
  logic [7:0]  s_data;
  logic        s_ready, m_valid, busy, err;
  logic [7:0]  m_data;
  logic [15:0] err_count;
  logic        nc_s_ready, nc_m_valid, nc_busy, nc_err;
  logic [7:0]  nc_m_data;
  logic [1:0]  nc_err_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  robber_stream_codec dut (
    .clk(clk), .reset(reset), .init(init), .encdec(encdec),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .err(err), .err_count(err_count)
  );

  // Second instance: plain filler for upper case and a 2-bit error counter.
  robber_stream_codec #(.FILLER(8'h6F), .CASE_FILLER(1'b0), .ERR_WIDTH(2)) dut_nc (
    .clk(clk), .reset(reset), .init(init), .encdec(encdec),
    .s_data(s_data), .s_valid(s_valid), .s_ready(nc_s_ready),
    .m_data(nc_m_data), .m_valid(nc_m_valid), .m_ready(m_ready),
    .busy(nc_busy), .err(nc_err), .err_count(nc_err_count)
  );

  typedef struct {
    logic        init;
    logic        encdec;
    logic [7:0]  sd;
    logic        sv;
    logic        mr;
    logic        ex_sr;
    logic        ex_mv;
    logic [7:0]  ex_md;
    logic        ex_err;
    logic [15:0] ex_cnt;
    logic        ex_busy;
    state_t      ex_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic in, logic ed, logic [7:0] sd, logic sv, logic mr,
                              logic sr, logic mv, logic [7:0] md, logic er,
                              logic [15:0] cnt, logic bz, state_t st);
    vec_t v;
    v.init = in; v.encdec = ed; v.sd = sd; v.sv = sv; v.mr = mr;
    v.ex_sr = sr; v.ex_mv = mv; v.ex_md = md; v.ex_err = er;
    v.ex_cnt = cnt; v.ex_busy = bz; v.ex_st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic in, input logic ed, input logic [7:0] sd,
                       input logic sv, input logic mr);
    init = in; encdec = ed; s_data = sd; s_valid = sv; m_ready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'h00);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    reset = 1'b0;

    // IDLE ignores input until init.
    drive(1'b0, 1'b1, "a", 1'b1, 1'b1);
    #1;
    chk("idle_s_ready", 32'(s_ready), 32'd0);
    tick();
    chk("idle_m_valid", 32'(m_valid), 32'd0);
    chk("idle_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Encode "b a"
    vecs.push_back(mk(1,1,8'h00,0,1, 0,0,8'h00,0,0,0,ST_ENC_PASS));
    vecs.push_back(mk(0,1,"b",1,1, 1,1,"b",0,0,1,ST_ENC_FILL));
    vecs.push_back(mk(0,1," ",1,1, 0,1,"o",0,0,1,ST_ENC_ECHO));
    vecs.push_back(mk(0,1," ",1,1, 0,1,"b",0,0,1,ST_ENC_PASS));
    vecs.push_back(mk(0,1," ",1,1, 1,1," ",0,0,1,ST_ENC_PASS));
    vecs.push_back(mk(0,1,"a",1,1, 1,1,"a",0,0,1,ST_ENC_PASS));
    vecs.push_back(mk(0,1,8'h00,0,1, 1,0,"a",0,0,0,ST_ENC_PASS));
    // Encode "Sa" with case-matched filler
    vecs.push_back(mk(0,1,"S",1,1, 1,1,"S",0,0,1,ST_ENC_FILL));
    vecs.push_back(mk(0,1,"a",1,1, 0,1,8'h4F,0,0,1,ST_ENC_ECHO));
    vecs.push_back(mk(0,1,"a",1,1, 0,1,"S",0,0,1,ST_ENC_PASS));
    vecs.push_back(mk(0,1,"a",1,1, 1,1,"a",0,0,1,ST_ENC_PASS));
    // Encode "Yz1": Y is a vowel, digit passes
    vecs.push_back(mk(0,1,"Y",1,1, 1,1,"Y",0,0,1,ST_ENC_PASS));
    vecs.push_back(mk(0,1,"z",1,1, 1,1,"z",0,0,1,ST_ENC_FILL));
    vecs.push_back(mk(0,1,"1",1,1, 0,1,"o",0,0,1,ST_ENC_ECHO));
    vecs.push_back(mk(0,1,"1",1,1, 0,1,"z",0,0,1,ST_ENC_PASS));
    vecs.push_back(mk(0,1,"1",1,1, 1,1,"1",0,0,1,ST_ENC_PASS));
    // init together with s_valid: input not taken, switch to decode
    vecs.push_back(mk(1,0,"q",1,1, 0,0,"1",0,0,0,ST_DEC_PASS));
    // Decode "hohejoj"
    vecs.push_back(mk(0,0,"h",1,1, 1,1,"h",0,0,1,ST_DEC_FILL));
    vecs.push_back(mk(0,0,"o",1,1, 1,0,"h",0,0,1,ST_DEC_ECHO));
    vecs.push_back(mk(0,0,"h",1,1, 1,0,"h",0,0,0,ST_DEC_PASS));
    vecs.push_back(mk(0,0,"e",1,1, 1,1,"e",0,0,1,ST_DEC_PASS));
    vecs.push_back(mk(0,0,"j",1,1, 1,1,"j",0,0,1,ST_DEC_FILL));
    vecs.push_back(mk(0,0,"o",1,1, 1,0,"j",0,0,1,ST_DEC_ECHO));
    vecs.push_back(mk(0,0,"j",1,1, 1,0,"j",0,0,0,ST_DEC_PASS));
    // Decode "hox" then "ox"
    vecs.push_back(mk(0,0,"h",1,1, 1,1,"h",0,0,1,ST_DEC_FILL));
    vecs.push_back(mk(0,0,"o",1,1, 1,0,"h",0,0,1,ST_DEC_ECHO));
    vecs.push_back(mk(0,0,"x",1,1, 1,1,"x",1,1,1,ST_DEC_FILL));
    vecs.push_back(mk(0,0,"o",1,1, 1,0,"x",0,1,1,ST_DEC_ECHO));
    vecs.push_back(mk(0,0,"x",1,1, 1,0,"x",0,1,0,ST_DEC_PASS));
    // Decode "SOS" (ok), then "So" (wrong-case filler)
    vecs.push_back(mk(0,0,"S",1,1, 1,1,"S",0,1,1,ST_DEC_FILL));
    vecs.push_back(mk(0,0,8'h4F,1,1, 1,0,"S",0,1,1,ST_DEC_ECHO));
    vecs.push_back(mk(0,0,"S",1,1, 1,0,"S",0,1,0,ST_DEC_PASS));
    vecs.push_back(mk(0,0,"S",1,1, 1,1,"S",0,1,1,ST_DEC_FILL));
    vecs.push_back(mk(0,0,"o",1,1, 1,1,"o",1,2,1,ST_DEC_PASS));
    // Echo mismatch "hok", then punctuation in DEC_FILL
    vecs.push_back(mk(0,0,"h",1,1, 1,1,"h",0,2,1,ST_DEC_FILL));
    vecs.push_back(mk(0,0,"o",1,1, 1,0,"h",0,2,1,ST_DEC_ECHO));
    vecs.push_back(mk(0,0,"k",1,1, 1,1,"k",1,3,1,ST_DEC_FILL));
    vecs.push_back(mk(0,0,"!",1,1, 1,1,"!",1,4,1,ST_DEC_PASS));
    // init clears the counter and drops the pending output
    vecs.push_back(mk(1,1,8'h00,0,1, 0,0,"!",0,0,0,ST_ENC_PASS));

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.init, v.encdec, v.sd, v.sv, v.mr);
      #1;
      chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(v.ex_sr));
      tick();
      $display("[TB] vec %0d init=%b sd=%h sv=%b -> mv=%b md=%h err=%b cnt=%0d",
               i, v.init, v.sd, v.sv, m_valid, m_data, err, err_count);
      chk($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(v.ex_mv));
      chk($sformatf("v%0d_m_data", i), 32'(m_data), 32'(v.ex_md));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(v.ex_err));
      chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(v.ex_cnt));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(v.ex_busy));
      chk($sformatf("v%0d_state", i), 32'(dut.state_q), 32'(v.ex_st));
    end

    // Encode "k" with the sink stalled for 5 cycles
    drive(1, 1, 8'h00, 0, 1); tick();
    drive(0, 1, "k", 1, 1); tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 8'h00, 0, 0);
      #1;
      chk($sformatf("stall%0d_s_ready", k), 32'(s_ready), 32'd0);
      tick();
      $display("[TB] stall %0d mv=%b md=%h", k, m_valid, m_data);
      chk($sformatf("stall%0d_m_data", k), 32'(m_data), 32'(8'h6B));
      chk($sformatf("stall%0d_m_valid", k), 32'(m_valid), 32'd1);
    end
    drive(0, 1, 8'h00, 0, 1); tick();
    chk("release_fill", 32'(m_data), 32'(8'h6F));
    chk("release_fill_v", 32'(m_valid), 32'd1);
    tick();
    chk("release_echo", 32'(m_data), 32'(8'h6B));
    chk("release_echo_v", 32'(m_valid), 32'd1);
    tick();
    chk("release_done_v", 32'(m_valid), 32'd0);
    $display("[TB] stall sequence done");

    // init while in ENC_FILL with a stalled output
    drive(1, 1, 8'h00, 0, 1); tick();
    drive(0, 1, "b", 1, 1); tick();
    drive(0, 1, 8'h00, 0, 0); tick();
    chk("initfill_pre_state", 32'(dut.state_q), 32'(ST_ENC_FILL));
    chk("initfill_pre_mv", 32'(m_valid), 32'd1);
    drive(1, 0, 8'h00, 0, 0);
    #1;
    chk("initfill_s_ready", 32'(s_ready), 32'd0);
    tick();
    chk("initfill_mv", 32'(m_valid), 32'd0);
    chk("initfill_state", 32'(dut.state_q), 32'(ST_DEC_PASS));
    drive(0, 0, 8'h00, 0, 1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("initfill_quiet%0d", k), 32'(m_valid), 32'd0);
    end
    $display("[TB] init-in-fill sequence done");

    // CASE_FILLER = 0 instance: "Sa" -> S,o,S,a
    drive(1, 1, 8'h00, 0, 1); tick();
    drive(0, 1, "S", 1, 1); tick();
    chk("nc_S", 32'(nc_m_data), 32'(8'h53));
    drive(0, 1, 8'h00, 0, 1); tick();
    chk("nc_filler", 32'(nc_m_data), 32'(8'h6F));
    tick();
    chk("nc_echo", 32'(nc_m_data), 32'(8'h53));
    drive(0, 1, "a", 1, 1); tick();
    chk("nc_a", 32'(nc_m_data), 32'(8'h61));
    $display("[TB] no-case-filler sequence done");

    // Repeated errors: 16-bit counter counts, 2-bit counter saturates at 3
    drive(1, 0, 8'h00, 0, 1); tick();
    drive(0, 0, "h", 1, 1); tick();
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, "x", 1, 1); tick();
      $display("[TB] sat %0d cnt=%0d nc_cnt=%0d", k, err_count, nc_err_count);
      chk($sformatf("sat%0d_cnt", k), 32'(err_count), 32'(k));
      chk($sformatf("sat%0d_nc_cnt", k), 32'(nc_err_count), 32'((k > 3) ? 3 : k));
      chk($sformatf("sat%0d_nc_err", k), 32'(nc_err), 32'd1);
    end

    // reset mid-decode
    drive(0, 0, 8'h00, 0, 1); tick();
    chk("pre_rst_cnt", 32'(err_count), 32'd5);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("mrst_m_valid", 32'(m_valid), 32'd0);
    chk("mrst_m_data", 32'(m_data), 32'h00);
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_err_count", 32'(err_count), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    drive(0, 0, "a", 1, 1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("mrst%0d_s_ready", k), 32'(s_ready), 32'd0);
      tick();
      chk($sformatf("mrst%0d_m_valid", k), 32'(m_valid), 32'd0);
    end
    $display("[TB] reset sequence done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/robber_stream_codec.md
# robber_stream_codec

Streaming, parametrised successor to the team's Rövarspråket core. Encodes or decodes 8-bit characters with full valid/ready handshakes on both sides and a configurable filler character. Upper-case consonants get a case-matched filler, and only alphabetic non-vowels count as consonants. In decode mode, malformed sequences are detected, counted and resynchronised. Sits between a byte-stream source (UART RX/FIFO) and sink in the text-processing datapath.

## Interface
- FILLER, 8'h6F ("o"), filler character inserted/expected after each consonant.
- CASE_FILLER, 1, if 1 an upper-case consonant uses FILLER & 8'hDF as filler.
- ERR_WIDTH, 16, width of saturating error counter.
- clk  in  1  clock; everything on rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  single-cycle pulse; flushes block, samples encdec.
- encdec  in  1  1 = encode, 0 = decode; sampled only when init = 1.
- s_data  in  8  input character.
- s_valid  in  1  input character valid.
- s_ready  out  1  block accepts s_data this cycle.
- m_data  out  8  output character (registered).
- m_valid  out  1  output valid (registered).
- m_ready  in  1  sink accepts m_data.
- busy  out  1  state is FILL/ECHO, or m_valid = 1.
- err  out  1  one-cycle pulse on a decode sequence error (registered).
- err_count  out  ERR_WIDTH  saturating count of decode errors.

## Operation
- Classification: letter = A-Z/a-z. Vowel = AEIOUY/aeiouy. Consonant = letter and not vowel. Digits, space, punctuation pass through unchanged.
- States: IDLE, ENC_PASS, ENC_FILL, ENC_ECHO, DEC_PASS, DEC_FILL, DEC_ECHO. Register `hold` stores the last consonant.
- out_free = !m_valid || m_ready.
- IDLE: s_ready = 0. Leave only on init.
- init (any state, highest priority after reset):
  - next state = encdec ? ENC_PASS : DEC_PASS;
  - m_valid <= 0, so any pending output is discarded;
  - err_count <= 0, err <= 0;
  - s_ready = 0 in the init cycle.
- ENC_PASS: s_ready = out_free. On accept: m_data <= s_data, m_valid <= 1. If consonant: hold <= s_data, go to ENC_FILL.
- ENC_FILL: s_ready = 0. When out_free: m_data <= filler(hold), go to ENC_ECHO.
- ENC_ECHO: s_ready = 0. When out_free: m_data <= hold, go to ENC_PASS.
- DEC_* states: s_ready = out_free in every state, including states that drop the character.
- DEC_PASS on accept: emit the character. If consonant: hold <= char, go to DEC_FILL.
- DEC_FILL on accept:
  - char == filler(hold): drop it, go to DEC_ECHO;
  - otherwise: error, and the char is processed exactly as in DEC_PASS.
- DEC_ECHO on accept:
  - char == hold (exact, case-sensitive): drop it, go to DEC_PASS;
  - otherwise: error, and the char is processed as in DEC_PASS.
- Error: err <= 1 for one cycle. err_count increments, saturating at all-ones.
- filler(c) = (CASE_FILLER && c in A-Z) ? FILLER & 8'hDF : FILLER.
- No timeout. A stream ending mid-sequence leaves the state pending until more input or init.

## Timing
- Reset values: s_ready 0, m_data 8'h00, m_valid 0, busy 0, err 0, err_count 0. State = IDLE, hold = 0.
- Latency: character accepted in cycle N appears on m_data/m_valid in cycle N+1.
- Encode throughput: non-consonants 1 char/cycle. A consonant occupies 3 output cycles, with s_ready low for the 2 cycles after acceptance when m_ready = 1.
- Decode throughput: 1 input/cycle when m_ready = 1.
- Output stability: while m_valid && !m_ready, m_data and m_valid hold their values, and no state advances that depends on out_free.
- s_ready is combinational from state registers and m_ready only; no path from s_valid.
- Simultaneous init and s_valid: the input is not accepted (s_ready = 0).
- Simultaneous m_ready and a new load: the output register is overwritten in the same cycle, with no bubble.
- reset mid-operation: all registers return to reset values next edge; the pending output is lost.

## Structure
- Package robber_pkg holds:
  - state enum/localparams;
  - vowel list constants;
  - functions is_letter, is_upper, filler_for(char, FILLER, CASE_FILLER).
- Sub-module robber_char_class: combinational classifier, 8-bit in, outputs is_letter/is_vowel/is_consonant/is_upper. Instantiated once on s_data.
- Top level contains the FSM, the hold register, the output register and the error counter. Expected size ~200-300 lines.

## Test plan
- Encode "b a", m_ready = 1: m_data sequence b,o,b,' ',a. s_ready low for exactly 2 cycles after b. Space passes unchanged.
- Encode "Sa", CASE_FILLER = 1: S,O,S,a. With CASE_FILLER = 0: S,o,S,a.
- Decode "hohejoj": output h,e,j. err never asserted, err_count = 0.
- Decode "hox": output h,x. err pulses once, err_count = 1, state ends in DEC_FILL (x is a consonant). Then "ox" gives no output and ends in DEC_PASS.
- Encode "k" with m_ready = 0 for 5 cycles: m_data = "k" held, m_valid = 1, s_ready = 0 throughout. After release: k,o,k on consecutive cycles.
- init pulse while in ENC_FILL with m_valid = 1: next cycle m_valid = 0, no filler or echo emitted, state = DEC_PASS when encdec = 0.
- reset pulse mid-decode: all outputs at reset values; s_ready stays 0 until init.
